// File: rtl/fpga_top_pkg.sv
// fpga_top_pkg: shared constants and state encodings for the UART GPIO bridge.
// Optional build macro used by fpga_top: FPGA_TOP_FLOW_CTRL_EN.
package fpga_top_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W': next byte goes to output_pins
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R': reply with sampled input_pins
  localparam int         CNT_W     = 12;     // baud counter width, covers CLK_DIV up to 4095

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_DATA
  } cmd_state_t;

  typedef enum logic [2:0] {
    RX_WAIT_HIGH,
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;
endpackage

// File: rtl/fpga_top_uart_core.sv
// uart_core: input synchronizers, 8N1 receiver and transmitter sharing one
// CLK_DIV bit period. Received bytes appear as a one-cycle rx_valid pulse the
// cycle after the stop-bit sample, together with the GPIO value seen at that sample.
module uart_core
  import fpga_top_pkg::*;
#(
  parameter int CLK_DIV = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       cts,
  input  logic [7:0] input_pins,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       txd,
  output logic       n_tx_en,
  output logic       tx_busy,
  output logic       cts_sync,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic [7:0] pins_snap
);
  localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_DIV / 2 - 1);

  logic [1:0]      rx_sync, cts_pipe;
  logic [1:0][7:0] pins_sync;
  logic            rx_s;

  // Two-flop synchronizers; serial lines reset to their idle/inhibit level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync   <= 2'b11;
      cts_pipe  <= 2'b11;
      pins_sync <= '0;
    end else begin
      rx_sync   <= {rx_sync[0], rxd};
      cts_pipe  <= {cts_pipe[0], cts};
      pins_sync <= {pins_sync[0], input_pins};
    end
  end

  assign rx_s     = rx_sync[1];
  assign cts_sync = cts_pipe[1];

  rx_state_t        rx_state, rx_next;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_tick;

  // The start bit is sampled half a period in; every later bit one full period on.
  assign rx_tick = (rx_state == RX_START) ? (rx_cnt == HALF_M1) : (rx_cnt == DIV_M1);

  // Receiver next state; after reset or a framing error the line must go high first.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_WAIT_HIGH: if (rx_s) rx_next = RX_IDLE;
      RX_IDLE:      if (!rx_s) rx_next = RX_START;
      RX_START:     if (rx_tick) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:      if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:      if (rx_tick) rx_next = rx_s ? RX_IDLE : RX_WAIT_HIGH;
      default:      rx_next = RX_WAIT_HIGH;
    endcase
  end

  // Receiver datapath: baud counter, shift register, byte hand-off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state  <= RX_WAIT_HIGH;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      pins_snap <= '0;
    end else begin
      rx_state <= rx_next;
      rx_valid <= 1'b0;
      if (rx_state inside {RX_WAIT_HIGH, RX_IDLE} || rx_tick) rx_cnt <= '0;
      else                                                 rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == RX_START) rx_bit <= '0;
      if (rx_state == RX_DATA && rx_tick) begin
        rx_shift <= {rx_s, rx_shift[7:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
      if (rx_state == RX_STOP && rx_tick && rx_s) begin
        rx_valid  <= 1'b1;
        rx_data   <= rx_shift;
        pins_snap <= pins_sync[1];
      end
    end
  end

  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_bit;
  logic [8:0]       tx_shift;

  // Transmitter: start bit goes out on the accept edge, then data LSB first, then stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy  <= 1'b0;
      txd      <= 1'b1;
      n_tx_en  <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx_busy  <= 1'b1;
        txd      <= 1'b0;
        n_tx_en  <= 1'b0;
        tx_shift <= {1'b1, tx_data};
        tx_cnt   <= '0;
        tx_bit   <= '0;
      end
    end else if (tx_cnt == DIV_M1) begin
      tx_cnt <= '0;
      if (tx_bit == 4'd9) begin
        tx_busy <= 1'b0;
        txd     <= 1'b1;
        n_tx_en <= 1'b1;
      end else begin
        txd      <= tx_shift[0];
        tx_shift <= {1'b0, tx_shift[8:1]};
        tx_bit   <= tx_bit + 1'b1;
      end
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/fpga_top.sv
// fpga_top: UART command bridge to 8 GPIO outputs/inputs.
// 'W' <byte> loads output_pins; 'R' replies with the sampled input_pins.
// Build macro FPGA_TOP_FLOW_CTRL_EN enables cts gating and rts busy indication.
module fpga_top
  import fpga_top_pkg::*;
#(
  parameter int CLK_DIV = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] input_pins,
  output logic [7:0] output_pins,
  input  logic       rxd,
  output logic       txd,
  input  logic       cts,
  output logic       rts,
  output logic       n_tx_en
);
  logic       rx_valid, tx_busy, tx_start, tx_ok, cts_sync;
  logic       pending, load_out, read_req;
  logic [7:0] rx_data, pins_snap, reply;
  cmd_state_t state, state_next;

  uart_core #(.CLK_DIV(CLK_DIV)) u_uart (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .cts        (cts),
    .input_pins (input_pins),
    .tx_start   (tx_start),
    .tx_data    (reply),
    .txd        (txd),
    .n_tx_en    (n_tx_en),
    .tx_busy    (tx_busy),
    .cts_sync   (cts_sync),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .pins_snap  (pins_snap)
  );

`ifdef FPGA_TOP_FLOW_CTRL_EN
  assign tx_ok = ~cts_sync;
  assign rts   = pending | tx_busy;
`else
  // cts is deliberately ignored in this build.
  logic unused_cts;
  assign unused_cts = cts_sync;
  assign tx_ok      = 1'b1;
  assign rts        = 1'b0;
`endif

  assign tx_start = pending & ~tx_busy & tx_ok;

  // Command state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Command decode on each received byte.
  always_comb begin
    state_next = state;
    load_out   = 1'b0;
    read_req   = 1'b0;
    if (rx_valid) begin
      case (state)
        ST_IDLE: begin
          if (rx_data == CMD_WRITE)     state_next = ST_WAIT_DATA;
          else if (rx_data == CMD_READ) read_req   = 1'b1;
        end
        ST_WAIT_DATA: begin
          load_out   = 1'b1;
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // GPIO output register and the single-entry read reply slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      output_pins <= '0;
      pending     <= 1'b0;
      reply       <= '0;
    end else begin
      if (load_out) output_pins <= rx_data;
      if (tx_start) pending <= 1'b0;
      else if (read_req && !pending && !tx_busy) begin
        pending <= 1'b1;
        reply   <= pins_snap;
      end
    end
  end
endmodule

// File: tb/tb_fpga_top.sv
// tb_fpga_top: directed checks of the UART GPIO bridge at CLK_DIV=87.
`timescale 1ns/1ps
module tb_fpga_top;
  localparam int DIV = 87;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       cts = 1'b0;
  logic [7:0] input_pins = 8'h00;
  logic [7:0] output_pins;
  logic       txd, rts, n_tx_en;

  int checks = 0;
  int failures = 0;
  int low_run = 0;
  int last_low = 0;
  int frames = 0;
  logic prev_en = 1'b1;

  always #50 clk = ~clk;

  fpga_top #(.CLK_DIV(DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .input_pins  (input_pins),
    .output_pins (output_pins),
    .rxd         (rxd),
    .txd         (txd),
    .cts         (cts),
    .rts         (rts),
    .n_tx_en     (n_tx_en)
  );

  // Length of each n_tx_en low window and number of frames started.
  always @(negedge clk) begin
    if (n_tx_en === 1'b0) low_run = low_run + 1;
    else if (low_run != 0) begin
      last_low = low_run;
      low_run  = 0;
    end
    if (prev_en === 1'b1 && n_tx_en === 1'b0) frames = frames + 1;
    prev_en = n_tx_en;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start bit plus 8 data bits; the caller drives the stop bit.
  task automatic send_bits(input logic [7:0] b);
    rxd = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(DIV);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bits(b);
    rxd = stop;
    tick(DIV);
    rxd = 1'b1;
    tick(DIV);
  endtask

  task automatic wait_txd_low(input int max, output bit found);
    found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      tick(1);
      if (txd === 1'b0) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(5);
    checks++; if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd got=%b want=1", txd); end
    checks++; if (n_tx_en !== 1'b1) begin failures++; $display("FAIL reset_n_tx_en got=%b want=1", n_tx_en); end
    checks++; if (rts !== 1'b0) begin failures++; $display("FAIL reset_rts got=%b want=0", rts); end
    checks++; if (output_pins !== 8'h00) begin failures++; $display("FAIL reset_out got=%h want=00", output_pins); end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_write();
    int f0;
    f0 = frames;
    send_frame(8'h57, 1'b1);
    send_bits(8'hA5);
    rxd = 1'b1;
    tick(40);
    checks++; if (output_pins !== 8'h00) begin failures++; $display("FAIL write_early got=%h want=00", output_pins); end
    tick(10);
    checks++; if (output_pins !== 8'hA5) begin failures++; $display("FAIL write_out got=%h want=a5", output_pins); end
    checks++; if (txd !== 1'b1) begin failures++; $display("FAIL write_txd got=%b want=1", txd); end
    tick(DIV);
    checks++; if (frames !== f0) begin failures++; $display("FAIL write_no_tx got=%0d want=%0d", frames, f0); end
  endtask

  task automatic test_ignore();
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    checks++; if (output_pins !== 8'hA5) begin failures++; $display("FAIL ignore_out got=%h want=a5", output_pins); end
  endtask

  task automatic test_read();
    logic [9:0] exp;
    bit found;
    int f0;
    f0 = frames;
    input_pins = 8'h3C;
    exp = {1'b1, 8'h3C, 1'b0};
    send_bits(8'h52);
    rxd = 1'b1;
    wait_txd_low(200, found);
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL read_start got=timeout want=start_bit"); end
    tick(DIV / 2);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (txd !== exp[i]) begin failures++; $display("FAIL read_bit%0d got=%b want=%b", i, txd, exp[i]); end
      tick(DIV);
    end
    checks++; if (last_low !== 870) begin failures++; $display("FAIL read_en_len got=%0d want=870", last_low); end
    checks++; if (frames !== f0 + 1) begin failures++; $display("FAIL read_frames got=%0d want=%0d", frames, f0 + 1); end
    checks++; if (n_tx_en !== 1'b1) begin failures++; $display("FAIL read_en_idle got=%b want=1", n_tx_en); end
  endtask

  task automatic test_back_to_back();
    bit found;
    int f0;
    send_bits(8'h52);
    rxd = 1'b1;
    wait_txd_low(200, found);
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL b2b_start got=timeout want=start_bit"); end
    tick(1);
    f0 = frames;
    send_frame(8'h52, 1'b1);
    tick(1000);
    checks++; if (frames !== f0) begin failures++; $display("FAIL b2b_drop got=%0d want=%0d", frames, f0); end
    checks++; if (output_pins !== 8'hA5) begin failures++; $display("FAIL b2b_out got=%h want=a5", output_pins); end
  endtask

  task automatic test_framing();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(4);
    send_frame(8'h57, 1'b0);
    send_frame(8'h11, 1'b1);
    checks++; if (output_pins !== 8'h00) begin failures++; $display("FAIL framing_out got=%h want=00", output_pins); end
    send_frame(8'h57, 1'b1);
    send_frame(8'h42, 1'b1);
    checks++; if (output_pins !== 8'h42) begin failures++; $display("FAIL framing_recover got=%h want=42", output_pins); end
  endtask

  task automatic test_reset_midframe();
    bit found;
    int f0;
    input_pins = 8'h5A;
    send_bits(8'h52);
    rxd = 1'b1;
    wait_txd_low(200, found);
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL mid_start got=timeout want=start_bit"); end
    tick(DIV * 4 + DIV / 2);
    f0 = frames;
    rst = 1'b1;
    #1;
    checks++; if (txd !== 1'b1) begin failures++; $display("FAIL mid_txd got=%b want=1", txd); end
    checks++; if (n_tx_en !== 1'b1) begin failures++; $display("FAIL mid_en got=%b want=1", n_tx_en); end
    tick(5);
    rst = 1'b0;
    tick(2000);
    checks++; if (frames !== f0) begin failures++; $display("FAIL mid_no_retx got=%0d want=%0d", frames, f0); end
    checks++; if (txd !== 1'b1) begin failures++; $display("FAIL mid_idle got=%b want=1", txd); end
  endtask

  task automatic test_flow();
    bit found;
    int f0;
`ifdef FPGA_TOP_FLOW_CTRL_EN
    cts = 1'b1;
    tick(4);
    f0 = frames;
    send_frame(8'h52, 1'b1);
    tick(100);
    checks++; if (txd !== 1'b1) begin failures++; $display("FAIL flow_hold_txd got=%b want=1", txd); end
    checks++; if (rts !== 1'b1) begin failures++; $display("FAIL flow_rts_busy got=%b want=1", rts); end
    checks++; if (frames !== f0) begin failures++; $display("FAIL flow_hold_frames got=%0d want=%0d", frames, f0); end
    cts = 1'b0;
    wait_txd_low(4, found);
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL flow_release got=timeout want=start_within_4"); end
    tick(DIV * 10 + 5);
    checks++; if (rts !== 1'b0) begin failures++; $display("FAIL flow_rts_done got=%b want=0", rts); end
    checks++; if (frames !== f0 + 1) begin failures++; $display("FAIL flow_frames got=%0d want=%0d", frames, f0 + 1); end
`else
    cts = 1'b1;
    tick(4);
    f0 = frames;
    send_bits(8'h52);
    rxd = 1'b1;
    wait_txd_low(200, found);
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL nofc_start got=timeout want=start_bit"); end
    checks++; if (rts !== 1'b0) begin failures++; $display("FAIL nofc_rts got=%b want=0", rts); end
    tick(DIV * 10 + 5);
    checks++; if (frames !== f0 + 1) begin failures++; $display("FAIL nofc_frames got=%0d want=%0d", frames, f0 + 1); end
    cts = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_ignore();
    test_read();
    test_back_to_back();
    test_framing();
    test_reset_midframe();
    test_flow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fpga_top.md
FPGA_TOP -- requirements
Module: fpga_top

Interface
REQ-001 Parameter CLK_DIV, default 87, means clk cycles per UART bit (115200 baud at 10 MHz); legal range 4..4095.
REQ-002 clk  input  1  sole clock, rising edge, 10 MHz nominal.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 input_pins  input  8  asynchronous GPIO inputs.
REQ-005 output_pins  output  8  registered GPIO outputs.
REQ-006 rxd  input  1  UART receive, idle high, asynchronous.
REQ-007 txd  output  1  UART transmit, idle high, registered.
REQ-008 cts  input  1  clear-to-send, active-low (0 = transmit permitted).
REQ-009 rts  output  1  request-to-send, active-low (0 = ready to accept commands).
REQ-010 n_tx_en  output  1  line-driver enable, active-low.

Function
REQ-011 UART framing SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each bit CLK_DIV cycles.
REQ-012 rxd and input_pins SHALL each pass through a 2-flop synchronizer before use.
REQ-013 RX SHALL detect a start on a synchronized 1->0 edge and sample each bit at CLK_DIV/2 (integer division) cycles into the bit.
- Start bit read as 1 at mid-bit: frame aborted, RX back to idle.
REQ-014 Stop bit read as 0 SHALL be a framing error: byte discarded, command FSM unchanged, RX waits for rxd=1 before re-arming.
REQ-015 Command FSM SHALL have states IDLE and WAIT_DATA.
- IDLE, byte 0x57 ('W') -> WAIT_DATA.
- IDLE, byte 0x52 ('R') -> set read-pending flag.
- IDLE, any other byte -> ignored.
- WAIT_DATA, any byte -> output_pins loaded, FSM to IDLE.
REQ-016 output_pins SHALL update on the clock edge after the data byte's stop-bit sample.
REQ-017 On a read request, the synchronized input_pins value SHALL be captured at the 'R' stop-bit sample and transmitted as one byte.
REQ-018 Only one read SHALL be pending; an 'R' arriving while a read is pending or its reply is transmitting SHALL be dropped.
REQ-019 TX SHALL drive the start bit no later than 2 cycles after the pending flag sets, when transmission is permitted.
REQ-020 n_tx_en SHALL be 0 from the first start-bit cycle through the last stop-bit cycle, and 1 otherwise.
REQ-021 TX SHALL clear the pending flag when the frame starts.

Reset
REQ-022 While rst=1: output_pins=0x00, txd=1, n_tx_en=1, rts=0, FSM in IDLE, pending flag cleared, RX and TX idle, all bit and baud counters cleared.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately, with txd=1 on the same cycle reset asserts.
REQ-024 After rst deasserts, RX SHALL re-arm only after seeing rxd=1.

Configuration
REQ-025 With macro FPGA_TOP_FLOW_CTRL_EN defined:
- TX SHALL start a frame only when synchronized cts=0; cts rising mid-frame does not interrupt the frame.
- rts SHALL be 1 while a read is pending or transmitting, and 0 otherwise.
REQ-026 Without FPGA_TOP_FLOW_CTRL_EN: cts is ignored and rts is tied to 0.

Structure
REQ-027 Package fpga_top_pkg SHALL hold the command constants (CMD_WRITE=8'h57, CMD_READ=8'h52) and the FSM state enum.
REQ-028 A sub-module uart_core (RX, TX, baud counters, synchronizers) SHALL be instantiated once; the command FSM, GPIO registers and flow control live in fpga_top.

Verification
REQ-029 Reset: rst=1 for 5 cycles -> txd=1, n_tx_en=1, rts=0, output_pins=0x00.
REQ-030 Write: send 0x57 then 0xA5 -> output_pins=0xA5 one cycle after the second stop-bit sample; txd stays 1.
REQ-031 Read: input_pins=0x3C, send 0x52 -> txd frame bits 0,0,0,1,1,1,1,0,0,1, each 87 cycles; n_tx_en=0 for exactly 870 cycles.
REQ-032 Framing error: send 0x57 with stop bit 0, then 0x11 -> output_pins unchanged at 0x00.
REQ-033 Flow control (macro defined): cts=1, send 0x52 -> txd stays 1 and rts=1; drop cts to 0 -> start bit within 4 cycles, rts=0 after the frame ends.
REQ-034 Reset mid-frame: assert rst during data bit 3 of a read reply -> txd=1 and n_tx_en=1 immediately; no further frame follows.
